// File: rtl/tcdm_arb_pkg.sv
// Shared types, default widths and pointer helper for the TCDM bank arbiters.
package tcdm_arb_pkg;

    localparam int unsigned NB_REQ_DEF = 4;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned ID_W_DEF   = 1;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef logic [$clog2(NB_REQ_DEF)-1:0] idx_t;

    // Round-robin successor: the slot after the winner, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned w, input int unsigned n);
        return (w + 1 >= n) ? 0 : w + 1;
    endfunction

endpackage

// File: rtl/tcdm_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
// Shared by the TCDM arbiters; holds no state.
module tcdm_rr_pick
    import tcdm_arb_pkg::*;
#(
    parameter  int unsigned N  = NB_REQ_DEF,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o,
    output logic [N-1:0]  gnt_o
);

    int unsigned cand;

    // Scan from the pointer outward; the first hit is the winner.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        gnt_o   = '0;
        cand    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = 32'(ptr_i) + i;
            if (cand >= N) cand = cand - N;
            if (!valid_o && req_i[cand[IW-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = cand[IW-1:0];
            end
        end
        for (int unsigned k = 0; k < N; k++) begin
            gnt_o[k] = valid_o && (idx_o == IW'(k));
        end
    end

endmodule

// File: rtl/tcdm_bank_rr_arbiter.sv
// Round-robin arbiter sharing one single-port TCDM bank among NbReq masters.
// Grant is combinational in the request cycle; the winner index and id ride a
// one-stage pipe so the response (reads and writes) returns to its master.
// Optional per-master conflict counters: define TCDM_ARB_PERF_EN.
module tcdm_bank_rr_arbiter
    import tcdm_arb_pkg::*;
#(
    parameter int unsigned NbReq     = NB_REQ_DEF,
    parameter int unsigned DataWidth = DATA_W_DEF,
    parameter int unsigned AddrWidth = ADDR_W_DEF,
    parameter int unsigned IdWidth   = ID_W_DEF,
    parameter int unsigned CntWidth  = CNT_W_DEF,
    localparam int unsigned BeWidth  = DataWidth / 8,
    localparam int unsigned IdxW     = $clog2(NbReq)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NbReq-1:0]                    req_i,
    output logic [NbReq-1:0]                    gnt_o,
    input  logic [NbReq-1:0][AddrWidth-1:0]     add_i,
    input  logic [NbReq-1:0]                    wen_i,
    input  logic [NbReq-1:0][DataWidth-1:0]     data_i,
    input  logic [NbReq-1:0][BeWidth-1:0]       be_i,
    input  logic [NbReq-1:0][IdWidth-1:0]       id_i,
    output logic [NbReq-1:0]                    r_valid_o,
    output logic [DataWidth-1:0]                r_data_o,
    output logic [IdWidth-1:0]                  r_id_o,
    output logic                                bank_req_o,
    output logic [AddrWidth-1:0]                bank_add_o,
    output logic                                bank_wen_o,
    output logic [DataWidth-1:0]                bank_data_o,
    output logic [BeWidth-1:0]                  bank_be_o,
    input  logic [DataWidth-1:0]                bank_r_data_i
`ifdef TCDM_ARB_PERF_EN
    ,
    output logic [NbReq-1:0][CntWidth-1:0]      perf_conf_o,
    input  logic                                perf_clr_i
`endif
);

    logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
    logic               rvld_q, rvld_d;
    logic [IdxW-1:0]    ridx_q, ridx_d;
    logic [IdWidth-1:0] rid_q, rid_d;
    logic               win_vld;
    logic [IdxW-1:0]    win_idx;

    tcdm_rr_pick #(.N(NbReq)) u_pick (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .valid_o (win_vld),
        .idx_o   (win_idx),
        .gnt_o   (gnt_o)
    );

    // Forward the winner's fields to the bank; idle bank sees all zeros.
    always_comb begin
        bank_req_o  = |req_i;
        bank_add_o  = '0;
        bank_wen_o  = 1'b0;
        bank_data_o = '0;
        bank_be_o   = '0;
        if (win_vld) begin
            bank_add_o  = add_i[win_idx];
            bank_wen_o  = wen_i[win_idx];
            bank_data_o = data_i[win_idx];
            bank_be_o   = be_i[win_idx];
        end
    end

    // Next pointer and response-stage contents.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (win_vld) rr_ptr_d = IdxW'(rr_next(32'(win_idx), NbReq));
        rvld_d = win_vld;
        ridx_d = win_idx;
        rid_d  = id_i[win_idx];
    end

    // Pointer and response stage; reset drops any in-flight response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            rvld_q   <= 1'b0;
            ridx_q   <= '0;
            rid_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rvld_q   <= rvld_d;
            ridx_q   <= ridx_d;
            rid_q    <= rid_d;
        end
    end

    // One-hot response valid back to the master granted last cycle.
    always_comb begin
        r_valid_o = '0;
        if (rvld_q) r_valid_o[ridx_q] = 1'b1;
    end

    // The bank's read data is already aligned with the response stage.
    assign r_data_o = bank_r_data_i;
    assign r_id_o   = rid_q;

`ifdef TCDM_ARB_PERF_EN
    logic [NbReq-1:0][CntWidth-1:0] cnt_q, cnt_d;

    // Count cycles each master waits; saturate, clear has priority.
    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned k = 0; k < NbReq; k++) begin
            if (perf_clr_i) cnt_d[k] = '0;
            else if (req_i[k] && !gnt_o[k] && (cnt_q[k] != '1)) cnt_d[k] = cnt_q[k] + 1'b1;
        end
    end

    // Conflict counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign perf_conf_o = cnt_q;
`endif

endmodule

// File: tb/tb_tcdm_bank_rr_arbiter.sv
// Directed bench for tcdm_bank_rr_arbiter: stimulus pushes expected grants and
// responses into queues; a negedge monitor pops and compares them.
module tb_tcdm_bank_rr_arbiter;

    logic clk = 1'b0;
    logic rst_ni;
    logic [3:0]        req_i;
    logic [3:0]        gnt_o;
    logic [3:0][31:0]  add_i;
    logic [3:0]        wen_i;
    logic [3:0][31:0]  data_i;
    logic [3:0][3:0]   be_i;
    logic [3:0][0:0]   id_i;
    logic [3:0]        r_valid_o;
    logic [31:0]       r_data_o;
    logic [0:0]        r_id_o;
    logic              bank_req_o;
    logic [31:0]       bank_add_o;
    logic              bank_wen_o;
    logic [31:0]       bank_data_o;
    logic [3:0]        bank_be_o;
    logic [31:0]       bank_r_data_i;
`ifdef TCDM_ARB_PERF_EN
    logic [3:0][15:0]  perf_conf_o;
    logic              perf_clr_i;
`endif

    always #5 clk = ~clk;

    tcdm_bank_rr_arbiter dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .add_i        (add_i),
        .wen_i        (wen_i),
        .data_i       (data_i),
        .be_i         (be_i),
        .id_i         (id_i),
        .r_valid_o    (r_valid_o),
        .r_data_o     (r_data_o),
        .r_id_o       (r_id_o),
        .bank_req_o   (bank_req_o),
        .bank_add_o   (bank_add_o),
        .bank_wen_o   (bank_wen_o),
        .bank_data_o  (bank_data_o),
        .bank_be_o    (bank_be_o),
        .bank_r_data_i(bank_r_data_i)
`ifdef TCDM_ARB_PERF_EN
        ,
        .perf_conf_o  (perf_conf_o),
        .perf_clr_i   (perf_clr_i)
`endif
    );

    // Bank model: 256 words, 1-cycle read latency, byte-enabled writes.
    logic [31:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
        bank_r_data_i = '0;
    end
    always @(posedge clk) begin
        if (bank_req_o) begin
            if (bank_wen_o) bank_r_data_i <= mem[bank_add_o[9:2]];
            else
                for (int b = 0; b < 4; b++)
                    if (bank_be_o[b]) mem[bank_add_o[9:2]][8*b +: 8] <= bank_data_o[8*b +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [3:0] gnt; logic [31:0] add; logic wen; } gexp_t;
    typedef struct { int cyc; logic [3:0] vld; logic id; logic rd; logic [31:0] data; } rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compare the grant/bank side and the response side each cycle.
    initial begin
        gexp_t g;
        rexp_t r;
        forever begin
            @(negedge clk);
            if (gq.size() > 0 && gq[0].cyc <= cyc) begin
                g = gq.pop_front();
                chk("gnt_cycle", 32'(cyc), 32'(g.cyc));
                chk("gnt", 32'(gnt_o), 32'(g.gnt));
                chk("bank_add", bank_add_o, g.add);
                chk("bank_wen", 32'(bank_wen_o), 32'(g.wen));
            end else if (|gnt_o) begin
                chk("unexpected_gnt", 32'(gnt_o), 32'h0);
            end
            if (rq.size() > 0 && rq[0].cyc <= cyc) begin
                r = rq.pop_front();
                chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
                chk("r_valid", 32'(r_valid_o), 32'(r.vld));
                chk("r_id", 32'(r_id_o), 32'(r.id));
                if (r.rd) chk("r_data", r_data_o, r.data);
            end else if (|r_valid_o) begin
                chk("unexpected_r_valid", 32'(r_valid_o), 32'h0);
            end
        end
    end

    // Drive one cycle of requests; w<0 means no grant expected.
    task automatic step(input logic [3:0] r, input int w, input logic [31:0] rdata, input bit rsp);
        req_i = r;
        if (w >= 0) begin
            gq.push_back('{cyc, 4'(1 << w), add_i[w], wen_i[w]});
            if (rsp) rq.push_back('{cyc + 1, 4'(1 << w), id_i[w][0], wen_i[w], rdata});
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        req_i  = '0;
        add_i  = {32'h8C, 32'h40, 32'h84, 32'h80};
        wen_i  = 4'b1111;
        data_i = '0;
        be_i   = {4'hF, 4'hF, 4'hF, 4'hF};
        id_i   = {1'b0, 1'b0, 1'b0, 1'b1};
`ifdef TCDM_ARB_PERF_EN
        perf_clr_i = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_r_valid", 32'(r_valid_o), 32'h0);
        chk("rst_r_id", 32'(r_id_o), 32'h0);
        chk("rst_bank_req", 32'(bank_req_o), 32'h0);
        chk("rst_bank_add", bank_add_o, 32'h0);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // Single master 2 read of 0x40 (ptr 0 -> 3).
        step(4'b0100, 2, 32'hA500_0010, 1);
        step(4'b0000, -1, 32'h0, 0);
        // Master 3 alone (ptr wraps to 0), then 0 and 3 together: 0 wins, id 1 echoed.
        step(4'b1000, 3, 32'hA500_0023, 1);
        step(4'b1001, 0, 32'hA500_0020, 1);
        step(4'b1000, 3, 32'hA500_0023, 1);
        // All four requesting from ptr 0: grants 0,1,2,3,0.
        add_i[2] = 32'h88;
        step(4'b1111, 0, 32'hA500_0020, 1);
        step(4'b1111, 1, 32'hA500_0021, 1);
        step(4'b1111, 2, 32'hA500_0022, 1);
        step(4'b1111, 3, 32'hA500_0023, 1);
        step(4'b1111, 0, 32'hA500_0020, 1);
        step(4'b0000, -1, 32'h0, 0);
        // Partial write by master 1 (ptr 1), then master 3 reads it back.
        add_i[1] = 32'h100; wen_i[1] = 1'b0; data_i[1] = 32'hDEAD_BEEF; be_i[1] = 4'b0011;
        step(4'b0010, 1, 32'h0, 1);
        add_i[3] = 32'h100;
        step(4'b1000, 3, 32'hA500_BEEF, 1);
        add_i[1] = 32'h84; wen_i[1] = 1'b1; data_i[1] = '0; be_i[1] = 4'hF; add_i[3] = 32'h8C;
        // Grant master 2 (ptr -> 3), then reset while its response is in flight.
        step(4'b0100, 2, 32'h0, 0);
        rst_ni = 1'b0;
        req_i  = '0;
        #1;
        chk("midrst_r_valid", 32'(r_valid_o), 32'h0);
        chk("midrst_r_id", 32'(r_id_o), 32'h0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        // Pointer is back at 0, so master 1 beats master 3.
        step(4'b1010, 1, 32'hA500_0021, 1);
        step(4'b0000, -1, 32'h0, 0);
`ifdef TCDM_ARB_PERF_EN
        perf_clr_i = 1'b1;
        step(4'b0000, -1, 32'h0, 0);
        perf_clr_i = 1'b0;
        for (int i = 0; i < 8; i++) step(4'b1111, (2 + i) % 4, 32'hA500_0020 + 32'((2 + i) % 4), 1);
        step(4'b0000, -1, 32'h0, 0);
        for (int k = 0; k < 4; k++) chk("perf_conf", 32'(perf_conf_o[k]), 32'd6);
        perf_clr_i = 1'b1;
        step(4'b0000, -1, 32'h0, 0);
        perf_clr_i = 1'b0;
        for (int k = 0; k < 4; k++) chk("perf_clr", 32'(perf_conf_o[k]), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("gnt_queue_drained", 32'(gq.size()), 32'h0);
        chk("rsp_queue_drained", 32'(rq.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
